mem_arbiter: RTL

//  Two-client arbiter upstream of the shared 16-bit unified memory. Instruction-fetch port (I) and

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter_rr_pick2.sv | 23 ++
 rtl/mem_arbiter.sv | 105 ++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory arbiter: FSM states, grant encoding, default widths.
// Pure declarations; no latency or backpressure of its own.
package mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int BE_W   = DATA_W / 8;

  localparam logic [BE_W-1:0] BE_ALL = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Client (I/D) and memory-side signals of the arbiter; slave = arbiter, master = environment.
// Requests are level-held until the matching one-cycle resp pulse.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);

  logic                      i_read;
  logic [ADDR_WIDTH-1:0]     i_address;
  logic                      i_resp;
  logic [DATA_WIDTH-1:0]     i_rdata;

  logic                      d_read;
  logic                      d_write;
  logic [DATA_WIDTH/8-1:0]   d_byte_enable;
  logic [ADDR_WIDTH-1:0]     d_address;
  logic [DATA_WIDTH-1:0]     d_wdata;
  logic                      d_resp;
  logic [DATA_WIDTH-1:0]     d_rdata;

  logic                      mem_read;
  logic                      mem_write;
  logic [DATA_WIDTH/8-1:0]   mem_byte_enable;
  logic [ADDR_WIDTH-1:0]     mem_address;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic                      mem_resp;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  modport slave (
    input  i_read, i_address,
    output i_resp, i_rdata,
    input  d_read, d_write, d_byte_enable, d_address, d_wdata,
    output d_resp, d_rdata,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata
  );

  modport master (
    output i_read, i_address,
    input  i_resp, i_rdata,
    output d_read, d_write, d_byte_enable, d_address, d_wdata,
    input  d_resp, d_rdata,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port not granted last.
// Purely combinational, no backpressure.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  grant_t last_grant,
  output logic   valid,
  output grant_t grant
);

  always_comb begin
    valid = req_i | req_d;
    grant = GNT_I;
    if (req_i && req_d) begin
      grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (req_d) begin
      grant = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin I/D arbiter onto one memory port, one transaction in flight, 1-cycle turnaround.
// Request->mem strobe 1 cycle, resp is combinational from mem_resp; clients hold requests until resp.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int BW = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_TURN = TURN;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  grant_t                r_grant;
  grant_t                r_last_grant;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BW-1:0]         r_be;

  logic                  w_req_i;
  logic                  w_req_d;
  logic                  w_tie;
  logic                  w_pick_vld;
  grant_t                w_pick_grant;
  logic                  w_grant_now;
  logic                  w_busy;

  assign w_req_i     = bus.i_read;
  assign w_req_d     = bus.d_read | bus.d_write;
  assign w_tie       = w_req_i & w_req_d;
  assign w_grant_now = (r_state == ST_IDLE) & w_pick_vld;
  assign w_busy      = (r_state == ST_BUSY);

  rr_pick2 u_pick (
    .req_i      (w_req_i),
    .req_d      (w_req_d),
    .last_grant (r_last_grant),
    .valid      (w_pick_vld),
    .grant      (w_pick_grant)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pick_vld)   w_state_nxt = ST_BUSY;
      ST_BUSY: if (bus.mem_resp) w_state_nxt = ST_TURN;
      ST_TURN:                   w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  // last_grant only moves on a tie, so a lone request never disturbs the tie-break order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= GNT_I;
      r_last_grant <= GNT_D;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_now) begin
        r_grant <= w_pick_grant;
        if (w_tie) begin
          r_last_grant <= w_pick_grant;
        end
        if (w_pick_grant == GNT_D) begin
          r_wr    <= bus.d_write;
          r_addr  <= bus.d_address;
          r_wdata <= bus.d_wdata;
          r_be    <= bus.d_byte_enable;
        end else begin
          r_wr    <= 1'b0;
          r_addr  <= bus.i_address;
          r_wdata <= '0;
          r_be    <= {BW{1'b1}};
        end
      end
    end
  end

  assign bus.mem_write       = w_busy & r_wr;
  assign bus.mem_read        = w_busy & ~r_wr;
  assign bus.mem_address     = r_addr;
  assign bus.mem_wdata       = r_wdata;
  assign bus.mem_byte_enable = r_be;

  // Gated by BUSY so a stray mem_resp in IDLE/TURN never reaches a client.
  assign bus.i_resp  = w_busy & bus.mem_resp & (r_grant == GNT_I);
  assign bus.d_resp  = w_busy & bus.mem_resp & (r_grant == GNT_D);
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

endmodule
